// File: rtl/mul_pkg.sv
// ============================================================================
// mul_pkg : shared widths, timeout default and sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int W_DEFAULT       = 16;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LDA   = 3'd2,
    S_LDB   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with registered count and full/empty flags
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_operand_sequencer.sv
// ============================================================================
// mul_operand_sequencer : queues operand pairs, drives the repeated-addition
// multiplier over its shared data bus and returns products with a watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_operand_sequencer
  import mul_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] mul_data,
  output logic         mul_start,
  input  logic         mul_done,
  input  logic [W-1:0] mul_product,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic         busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [WDW-1:0]  r_wdog;
  logic [2*W-1:0]  w_fifo_dout;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_wd_clr;
  logic            w_res_done;
  logic            w_res_abort;

  assign op_ready = ~w_fifo_full;
  assign busy     = (r_state != S_IDLE);

  sync_fifo #(
    .WIDTH (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (op_valid & op_ready),
    .din   ({op_a, op_b}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // A launch is held off while a result is still waiting in the single slot.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    mul_start   = 1'b0;
    mul_data    = '0;
    w_wd_clr    = 1'b0;
    w_res_done  = 1'b0;
    w_res_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty && !res_valid) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        mul_start   = 1'b1;
        mul_data    = r_a;
        w_state_nxt = S_LDA;
      end
      S_LDA: begin
        mul_data    = r_a;
        w_state_nxt = S_LDB;
      end
      S_LDB: begin
        mul_data    = r_b;
        w_wd_clr    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mul_data = r_b;
        if (mul_done) begin
          w_res_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
          w_res_abort = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_wdog    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_a <= w_fifo_dout[2*W-1:W];
        r_b <= w_fifo_dout[W-1:0];
      end
      if (w_wd_clr)              r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + WDW'(1);
      if (w_res_done) begin
        res_data  <= mul_product;
        res_err   <= 1'b0;
        res_valid <= 1'b1;
      end else if (w_res_abort) begin
        res_data  <= '0;
        res_err   <= 1'b1;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_operand_sequencer.sv
// ============================================================================
// tb_mul_operand_sequencer : directed vectors against a repeated-addition
// multiplier model sharing the data bus
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_operand_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] mul_data;
  logic         mul_start;
  logic         mul_done;
  logic [W-1:0] mul_product;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         busy;
  logic         stub_hang = 1'b0;

  int vectors = 0;
  int fails   = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  mul_operand_sequencer #(.W(W), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .mul_data    (mul_data),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy)
  );

  // Multiplier model: start, load A, load B, then add A to Y B times.
  logic [1:0]   m_phase;
  logic [W-1:0] m_a, m_y, m_cnt;
  logic         m_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 2'd0; m_a <= '0; m_y <= '0; m_cnt <= '0; m_done <= 1'b0;
    end else if (mul_start) begin
      m_phase <= 2'd1; m_done <= 1'b0;
    end else begin
      case (m_phase)
        2'd1: begin m_a <= mul_data; m_y <= '0; m_phase <= 2'd2; end
        2'd2: begin m_cnt <= mul_data; m_phase <= 2'd3; end
        2'd3: begin
          if (m_cnt == '0) begin m_done <= 1'b1; m_phase <= 2'd0; end
          else begin m_y <= m_y + m_a; m_cnt <= m_cnt - 1'b1; end
        end
        default: ;
      endcase
    end
  end

  assign mul_done    = stub_hang ? 1'b0 : m_done;
  assign mul_product = m_y;

  always_ff @(posedge clk) if (mul_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the pair was accepted.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b;
    while (!op_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("result_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mul_start && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("start_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         err;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   s0, n;
    logic stable;
    vecs[0] = '{16'd3,     16'd4, 16'd12,    1'b0};
    vecs[1] = '{16'd0,     16'd9, 16'd0,     1'b0};
    vecs[2] = '{16'd7,     16'd0, 16'd0,     1'b0};
    vecs[3] = '{16'd255,   16'd2, 16'd510,   1'b0};
    vecs[4] = '{16'd40000, 16'd3, 16'd54464, 1'b0};
    vecs[5] = '{16'd65535, 16'd1, 16'd65535, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_mul_data",  32'(mul_data), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data), 32'd0);
    chk("rst_res_err",   32'(res_err), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd1);

    // Single job, bus sequence A,A,B
    res_ready = 1'b1;
    s0 = start_cnt;
    push(16'd17, 16'd5);
    wait_start();
    chk("seq_data0", 32'(mul_data), 32'd17);
    @(negedge clk);
    chk("seq_data1", 32'(mul_data), 32'd17);
    chk("seq_start_pulse", 32'(mul_start), 32'd0);
    @(negedge clk);
    chk("seq_data2", 32'(mul_data), 32'd5);
    wait_res();
    chk("seq_res_data", 32'(res_data), 32'd85);
    chk("seq_res_err",  32'(res_err), 32'd0);
    chk("seq_start_once", 32'(start_cnt - s0), 32'd1);
    @(negedge clk);

    // Table-driven jobs
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].a, vecs[i].b);
      wait_res();
      chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_err", i),  32'(res_err), 32'(vecs[i].err));
      @(negedge clk);
    end

    // FIFO fill behind a stalled result slot
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(vecs[i].a, vecs[i].b);
    push(16'd1000, 16'd9);
    chk("fill_op_ready", 32'(op_ready), 32'd0);
    wait_res();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_res();
      chk($sformatf("fill%0d_data", i), 32'(res_data),
          (i == 4) ? 32'd9000 : 32'(vecs[i].exp));
      @(negedge clk);
    end
    chk("drain_op_ready", 32'(op_ready), 32'd1);

    // Watchdog abort, then a normal job
    stub_hang = 1'b1;
    push(16'd9, 16'd9);
    push(16'd6, 16'd7);
    wait_start();
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk("wd_latency", 32'(n), 32'd19);
    chk("wd_err",  32'(res_err), 32'd1);
    chk("wd_data", 32'(res_data), 32'd0);
    stub_hang = 1'b0;
    @(negedge clk);
    wait_res();
    chk("wd_next_data", 32'(res_data), 32'd42);
    chk("wd_next_err",  32'(res_err), 32'd0);
    @(negedge clk);

    // Reset during S_WAIT
    push(16'd100, 16'd50);
    wait_start();
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy || res_valid) stable = 1'b0;
    end
    chk("midrst_quiet", 32'(stable), 32'd1);
    chk("midrst_op_ready", 32'(op_ready), 32'd1);
    push(16'd6, 16'd7);
    wait_res();
    chk("midrst_data", 32'(res_data), 32'd42);
    @(negedge clk);

    // Held result stays stable and blocks new launches
    res_ready = 1'b0;
    push(16'd10, 16'd3);
    push(16'd4, 16'd5);
    wait_res();
    s0 = start_cnt;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || res_data !== 16'd30 || res_err !== 1'b0) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    chk("hold_no_start", 32'(start_cnt - s0), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    wait_res();
    chk("hold_next_data", 32'(res_data), 32'd20);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
